// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: decodes the ID instruction for the ALU,
// forwards EX/MEM and MEM/WB results, and stalls ID on load-use.
module id_ex_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [31:0] id_instr,
    input  logic [31:0] id_rs_data,
    input  logic [31:0] id_rt_data,
    input  logic [31:0] id_pc_plus4,
    input  logic        flush,
    input  logic        exm_wr_en,
    input  logic [4:0]  exm_wr_reg,
    input  logic [31:0] exm_wr_data,
    input  logic        wb_wr_en,
    input  logic [4:0]  wb_wr_reg,
    input  logic [31:0] wb_wr_data,
    output logic        id_stall,
    output logic        ex_valid,
    output logic [3:0]  ex_alu_ctrl,
    output logic [31:0] ex_in1,
    output logic [31:0] ex_in2,
    output logic [31:0] ex_store_data,
    output logic [4:0]  ex_wr_reg,
    output logic        ex_reg_write,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic        ex_branch,
    output logic        ex_jump_reg,
    output logic        ex_link,
    output logic [31:0] ex_pc_plus4,
    output logic        ex_illegal
);

    typedef struct packed {
        logic        valid;
        logic [3:0]  alu;
        logic [31:0] a;
        logic [4:0]  a_reg;
        logic [31:0] b;
        logic        b_is_reg;
        logic [4:0]  rt;
        logic [31:0] st;
        logic [4:0]  wr_reg;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        jump_reg;
        logic        link;
        logic        illegal;
        logic [31:0] pc4;
    } id_ex_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SLL   = 6'b000000;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_JR    = 6'b001000;
    localparam logic [5:0] F_SLT   = 6'b101010;

    id_ex_t d;
    id_ex_t q;

    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] sext;
    logic [31:0] zext;
    logic [31:0] shamt;
    logic        is_r;
    logic        uses_rt;

    assign op    = id_instr[31:26];
    assign fn    = id_instr[5:0];
    assign rs    = id_instr[25:21];
    assign rt    = id_instr[20:16];
    assign rd    = id_instr[15:11];
    assign sext  = {{16{id_instr[15]}}, id_instr[15:0]};
    assign zext  = {16'h0, id_instr[15:0]};
    assign shamt = {27'h0, id_instr[10:6]};
    assign is_r  = (op == OP_R);

    // EX/MEM wins over MEM/WB; register 0 is never forwarded
    function automatic logic [31:0] fwd(
        input logic [4:0]  r,
        input logic [31:0] v,
        input logic        e1,
        input logic [4:0]  r1,
        input logic [31:0] d1,
        input logic        e2,
        input logic [4:0]  r2,
        input logic [31:0] d2
    );
        if (e1 && r1 == r && r != 5'd0)
            return d1;
        else if (e2 && r2 == r && r != 5'd0)
            return d2;
        return v;
    endfunction

    // decode the ID instruction into the EX bundle
    always_comb begin
        d          = '0;
        d.valid    = 1'b1;
        d.a        = id_rs_data;
        d.a_reg    = rs;
        d.b        = id_rt_data;
        d.b_is_reg = 1'b1;
        d.rt       = rt;
        d.st       = id_rt_data;
        d.pc4      = id_pc_plus4;
        unique case (1'b1)
            is_r && fn == F_ADD: begin
                d.alu    = 4'd0;
                d.wr_reg = rd;
            end
            op == OP_ADDI: begin
                d.alu      = 4'd1;
                d.wr_reg   = rt;
                d.b        = sext;
                d.b_is_reg = 1'b0;
            end
            op == OP_LW: begin
                d.alu      = 4'd2;
                d.wr_reg   = rt;
                d.mem_read = 1'b1;
                d.b        = sext;
                d.b_is_reg = 1'b0;
            end
            op == OP_SW: begin
                d.alu       = 4'd3;
                d.mem_write = 1'b1;
                d.b         = sext;
                d.b_is_reg  = 1'b0;
            end
            is_r && fn == F_SLL: begin
                d.alu      = 4'd4;
                d.wr_reg   = rd;
                d.a        = id_rt_data;
                d.a_reg    = rt;
                d.b        = shamt;
                d.b_is_reg = 1'b0;
            end
            is_r && fn == F_AND: begin
                d.alu    = 4'd5;
                d.wr_reg = rd;
            end
            op == OP_ANDI: begin
                d.alu      = 4'd6;
                d.wr_reg   = rt;
                d.b        = zext;
                d.b_is_reg = 1'b0;
            end
            is_r && fn == F_NOR: begin
                d.alu    = 4'd7;
                d.wr_reg = rd;
            end
            op == OP_BEQ: begin
                d.alu    = 4'd8;
                d.branch = 1'b1;
            end
            op == OP_JAL: begin
                d.alu    = 4'd9;
                d.wr_reg = 5'd31;
                d.link   = 1'b1;
            end
            is_r && fn == F_JR: begin
                d.alu      = 4'd10;
                d.jump_reg = 1'b1;
            end
            is_r && fn == F_SLT: begin
                d.alu    = 4'd11;
                d.wr_reg = rd;
            end
            default: d.illegal = 1'b1;
        endcase
        d.reg_write = (d.wr_reg != 5'd0);
    end

    // load-use: a load in EX feeds a register ID is reading
    always_comb begin
        uses_rt  = is_r || op == OP_SW || op == OP_BEQ;
        id_stall = q.valid && q.mem_read && q.wr_reg != 5'd0 &&
                   id_valid &&
                   (rs == q.wr_reg || (uses_rt && rt == q.wr_reg));
    end

    // pipeline register; reset, flush, stall and empty ID all give a bubble
    always_ff @(posedge clk) begin
        if (!rst_n || flush || id_stall || !id_valid)
            q <= '0;
        else
            q <= d;
    end

    assign ex_in1 = fwd(q.a_reg, q.a,
                        exm_wr_en, exm_wr_reg, exm_wr_data,
                        wb_wr_en, wb_wr_reg, wb_wr_data);
    assign ex_in2 = q.b_is_reg ?
                    fwd(q.rt, q.b,
                        exm_wr_en, exm_wr_reg, exm_wr_data,
                        wb_wr_en, wb_wr_reg, wb_wr_data) : q.b;
    assign ex_store_data = fwd(q.rt, q.st,
                        exm_wr_en, exm_wr_reg, exm_wr_data,
                        wb_wr_en, wb_wr_reg, wb_wr_data);

    assign ex_valid     = q.valid;
    assign ex_alu_ctrl  = q.alu;
    assign ex_wr_reg    = q.wr_reg;
    assign ex_reg_write = q.reg_write;
    assign ex_mem_read  = q.mem_read;
    assign ex_mem_write = q.mem_write;
    assign ex_branch    = q.branch;
    assign ex_jump_reg  = q.jump_reg;
    assign ex_link      = q.link;
    assign ex_pc_plus4  = q.pc4;
    assign ex_illegal   = q.illegal;

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage of the MIPS CPU, directly upstream of the ALU. It decodes the instruction leaving ID into the ALU's 4-bit operation code and control flags, and registers operands and destination for one cycle. It also applies EX/MEM and MEM/WB forwarding to the ALU operands and detects load-use hazards, stalling ID and inserting a bubble.

## Interface
Parameters:
- none (datapath fixed at 32 bits, 5-bit register numbers)

Ports:
- clk  in  1  rising-edge clock; one clock domain
- rst_n  in  1  synchronous, active-low reset
- id_valid  in  1  ID holds a real instruction
- id_instr  in  32  instruction word in ID
- id_rs_data, id_rt_data  in  32 each  register-file read data for rs/rt
- id_pc_plus4  in  32  PC+4 of ID instruction
- flush  in  1  kill the ID instruction (branch/jump taken)
- exm_wr_en, exm_wr_reg, exm_wr_data  in  1/5/32  EX/MEM writeback candidate
- wb_wr_en, wb_wr_reg, wb_wr_data  in  1/5/32  MEM/WB writeback candidate
- id_stall  out  1  hold PC and IF/ID this cycle (combinational)
- ex_valid  out  1  EX holds a real instruction
- ex_alu_ctrl  out  4  ALU operation code
- ex_in1, ex_in2  out  32 each  forwarded ALU operands
- ex_store_data  out  32  forwarded rt value for SW
- ex_wr_reg  out  5  destination register
- ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump_reg, ex_link  out  1 each  control flags
- ex_pc_plus4  out  32  carried PC+4 (JAL link value)
- ex_illegal  out  1  unsupported opcode/funct in EX

## Operation
- Decode (opcode[31:26], funct[5:0]) → ex_alu_ctrl: R/100000 ADD 0000; ADDI 001000 → 0001; LW 100011 → 0010; SW 101011 → 0011; R/000000 SLL 0100; R/100100 AND 0101; ANDI 001100 → 0110; R/100111 NOR 0111; BEQ 000100 → 1000; JAL 000011 → 1001; R/001000 JR 1010; R/101010 SLT 1011.
- Unsupported encoding: ex_illegal=1, all write/mem/branch flags 0, alu_ctrl 0000; ex_valid follows id_valid.
- Destination: R-type rd; ADDI/ANDI/LW rt; JAL 31; none for SW/BEQ/JR. ex_reg_write forced 0 if destination is 0.
- Operand B selection (registered): ADDI/LW/SW sign-extended imm[15:0]; ANDI zero-extended imm; SLL zero-extended shamt[10:6]; all others rt. Operand A: rs, except SLL uses rt.
- Forwarding (combinational on EX outputs, per source register of operand A, operand B-when-register, and store data): if exm_wr_en and exm_wr_reg matches and ≠0 → exm_wr_data; else if wb_wr_en and wb_wr_reg matches and ≠0 → wb_wr_data; else the registered value. EX/MEM has priority.
- Load-use: id_stall=1 when ex_valid & ex_mem_read & ex_wr_reg≠0 & id_valid and ID reads ex_wr_reg as rs or rt (rt only for R-type, SW, BEQ).
- Register update each edge: rst_n=0 → bubble; else flush or id_stall → bubble; else load decoded ID instruction. Bubble = ex_valid 0, all flags 0, ex_illegal 0, data fields 0.

## Timing
- Reset: every registered output 0; ex_valid 0; id_stall 0 whilst ex_valid 0.
- Latency: instruction in ID at edge N appears on ex_* after edge N; forwarded operands valid same cycle as exm/wb inputs.
- Stall: exactly one bubble per load-use; ID instruction advances on the following edge (forwarded from MEM/WB).
- flush and id_stall together: bubble inserted; flush has priority, no double bubble.
- Reset asserted mid-stall: bubble on next edge, id_stall drops when ex_valid clears.

## Test plan
- Reset: rst_n=0 one edge → ex_valid=0, ex_alu_ctrl=0, ex_reg_write=0, id_stall=0.
- ADDI $2,$1,-4 (0x2022FFFC), rs_data=10 → next cycle ex_alu_ctrl=0001, in1=10, in2=0xFFFFFFFC, wr_reg=2, reg_write=1.
- ADD $3,$2,$2 after EX/MEM wr $2=6 and MEM/WB wr $2=9 → in1=in2=6 (EX/MEM priority).
- LW $4,0($1) then AND $5,$4,$4 → id_stall=1 one cycle, one bubble, AND reaches EX with wb data forwarded.
- flush=1 with valid ID BEQ → next cycle ex_valid=0, ex_branch=0.
- ADD to $0 with exm_wr_reg=0, exm_wr_data=0xDEAD → ex_reg_write=0, no forwarding from reg 0; JAL → wr_reg=31, ex_link=1, alu_ctrl=1001.
